insn_buffer: RTL
================

INSN_BUFFER -- requirements
Module: insn_buffer

Interface
REQ-001 Parameter: DEPTH, default 8, number of instruction entries (power of two, >=4).
REQ-002 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 Port: rst_  input  1  reset, asynchronous, active-high (asserted = 1).
REQ-004 Port: flush  input  1  synchronous discard of all buffered entries.
REQ-005 Port: if_ib_pc_0 / if_ib_pc_1  input  32 each  fetch-slot PCs.
REQ-006 Port: if_ib_insn_0 / if_ib_insn_1  input  32 each  fetch-slot instruction words.
REQ-007 Port: if_ib_ptab_addr_0 / if_ib_ptab_addr_1  input  5 each  prediction-table index per slot.
REQ-008 Port: if_ib_valid_0 / if_ib_valid_1  input  1 each  per-slot valid.
REQ-009 Port: if_valid_ns  input  1  fetch group offered this cycle.
REQ-010 Port: ib_allin  output  1  buffer can accept a 2-slot group.
REQ-011 Port: ib_id_pc_0 / ib_id_pc_1  output  32 each  head and head+1 PCs.
REQ-012 Port: ib_id_insn_0 / ib_id_insn_1  output  32 each  head and head+1 instructions.
REQ-013 Port: ib_id_ptab_addr_0 / ib_id_ptab_addr_1  output  5 each  head and head+1 ptab indices.
REQ-014 Port: ib_id_valid_0 / ib_id_valid_1  output  1 each  head / head+1 entry present.
REQ-015 Port: ib_valid_ns  output  1  at least one entry available to decode.
REQ-016 Port: id_allin  input  1  decode stage accepts the presented pair this cycle.

Function
REQ-017 Storage: circular array of DEPTH entries {pc, insn, ptab_addr}; head/tail pointers log2(DEPTH) bits, wrap modulo DEPTH; count log2(DEPTH)+1 bits, range 0..DEPTH.
REQ-018 ib_allin = (DEPTH - count) >= 2, combinational from registered count only (no dependence on id_allin).
REQ-019 Push condition: if_valid_ns && ib_allin; entries written = if_ib_valid_0 + if_ib_valid_1 (0, 1 or 2).
REQ-020 Push compaction: valid slots written in slot order to tail, tail+1; slot 1 alone goes to tail; no holes stored.
REQ-021 Push with both slot valids 0: no write, no count change.
REQ-022 ib_valid_ns = (count >= 1); ib_id_valid_0 = (count >= 1); ib_id_valid_1 = (count >= 2).
REQ-023 Slot 0 outputs = entry[head], slot 1 outputs = entry[head+1 mod DEPTH], combinational; each slot's pc/insn/ptab_addr output SHALL be zero when its valid is 0.
REQ-024 Pop condition: ib_valid_ns && id_allin; entries removed = 2 if count >= 2, else 1; head advances by that amount.
REQ-025 Simultaneous push and pop: count_next = count + pushed - popped; write and read use pre-edge pointers; a pushed entry is never presented in the same cycle it is written (zero bypass, 1-cycle minimum latency IF->ID).
REQ-026 Full (count = DEPTH or DEPTH-1): ib_allin = 0; offered group is ignored and not written, regardless of same-cycle pop.
REQ-027 Empty (count = 0): ib_valid_ns = 0; id_allin ignored; no pop.
REQ-028 flush: next cycle head = tail = count = 0; any same-cycle push and pop discarded; flush overrides push/pop.
REQ-029 Pointer wrap: entry at index DEPTH-1 followed by index 0 for both write and read; slot-1 output at head = DEPTH-1 reads index 0.

Reset
REQ-030 rst_ = 1 asynchronously forces head = 0, tail = 0, count = 0, regardless of clk.
REQ-031 During and after reset: ib_allin = 1, ib_valid_ns = 0, ib_id_valid_0/1 = 0, all ib_id_pc/insn/ptab_addr outputs = 0.
REQ-032 Reset asserted mid-operation discards all entries; entry array contents need not be cleared.

Verification
REQ-033 Reset, then push {pc 0x1000 insn A ptab 1, pc 0x1004 insn B ptab 2}, id_allin = 0 -> next cycle valid_0 = valid_1 = 1, pc_0 = 0x1000, pc_1 = 0x1004, count = 2.
REQ-034 Push 4 full groups with id_allin = 0 (DEPTH 8) -> count = 8, ib_allin = 0; 5th offered group not stored; then id_allin = 1 for one cycle -> count = 6, ib_allin = 1.
REQ-035 Push only slot 1 (pc 0x2004) into empty buffer -> next cycle valid_0 = 1, pc_0 = 0x2004, valid_1 = 0, pc_1 = 0.
REQ-036 count = 3, push 2 and pop in same cycle -> count = 3, head +2; remaining order preserved across wrap at index 7->0.
REQ-037 count = 5, flush = 1 with concurrent push and pop -> next cycle count = 0, ib_valid_ns = 0, ib_allin = 1.
REQ-038 rst_ pulsed between clock edges with count = 4 -> outputs immediately show valid_0/1 = 0, ib_allin = 1 before next edge.

Source files
------------

// File: rtl/insn_buffer.sv
// Instruction buffer between fetch and decode: a circular queue that accepts
// up to two instructions per cycle from IF and presents the two oldest to ID.
module insn_buffer #(
  parameter int unsigned DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst_,
  input  logic        flush,
  // fetch side
  input  logic [31:0] if_ib_pc_0,
  input  logic [31:0] if_ib_pc_1,
  input  logic [31:0] if_ib_insn_0,
  input  logic [31:0] if_ib_insn_1,
  input  logic [4:0]  if_ib_ptab_addr_0,
  input  logic [4:0]  if_ib_ptab_addr_1,
  input  logic        if_ib_valid_0,
  input  logic        if_ib_valid_1,
  input  logic        if_valid_ns,
  output logic        ib_allin,
  // decode side
  output logic [31:0] ib_id_pc_0,
  output logic [31:0] ib_id_pc_1,
  output logic [31:0] ib_id_insn_0,
  output logic [31:0] ib_id_insn_1,
  output logic [4:0]  ib_id_ptab_addr_0,
  output logic [4:0]  ib_id_ptab_addr_1,
  output logic        ib_id_valid_0,
  output logic        ib_id_valid_1,
  output logic        ib_valid_ns,
  input  logic        id_allin
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] insn;
    logic [4:0]  ptab_addr;
  } entry_t;

  entry_t             mem [DEPTH];
  logic [PTR_W-1:0]   head_q;
  logic [PTR_W-1:0]   tail_q;
  logic [CNT_W-1:0]   count_q;

  logic [PTR_W-1:0]   head_d;
  logic [PTR_W-1:0]   tail_d;
  logic [CNT_W-1:0]   count_d;
  logic [PTR_W-1:0]   head_p1;
  logic [PTR_W-1:0]   wr1_idx;
  logic               push_en;
  logic               pop_en;
  logic [1:0]         n_push;
  logic [1:0]         n_pop;
  logic               wr0;
  logic               wr1;
  entry_t             rd0;
  entry_t             rd1;

  // Occupancy flags and push/pop decisions from registered state and inputs.
  always_comb begin
    ib_allin    = (count_q <= CNT_W'(DEPTH - 2));
    ib_valid_ns = (count_q >= CNT_W'(1));
    push_en     = if_valid_ns && ib_allin && !flush;
    pop_en      = ib_valid_ns && id_allin && !flush;
    n_push      = push_en ? (2'({1'b0, if_ib_valid_0}) + 2'({1'b0, if_ib_valid_1})) : 2'd0;
    n_pop       = pop_en ? ((count_q >= CNT_W'(2)) ? 2'd2 : 2'd1) : 2'd0;
    wr0         = push_en && if_ib_valid_0;
    wr1         = push_en && if_ib_valid_1;
    // slot 1 lands right after slot 0, or at tail when slot 0 is empty
    wr1_idx     = tail_q + PTR_W'(if_ib_valid_0);
    head_d      = head_q + PTR_W'(n_pop);
    tail_d      = tail_q + PTR_W'(n_push);
    count_d     = count_q + CNT_W'(n_push) - CNT_W'(n_pop);
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage; contents are meaningless outside head..tail so no reset.
  always_ff @(posedge clk) begin
    if (wr0) begin
      mem[tail_q] <= '{pc: if_ib_pc_0, insn: if_ib_insn_0, ptab_addr: if_ib_ptab_addr_0};
    end
    if (wr1) begin
      mem[wr1_idx] <= '{pc: if_ib_pc_1, insn: if_ib_insn_1, ptab_addr: if_ib_ptab_addr_1};
    end
  end

  // Present the two oldest entries, zeroed when not present.
  always_comb begin
    head_p1           = head_q + PTR_W'(1);
    rd0               = mem[head_q];
    rd1               = mem[head_p1];
    ib_id_valid_0     = (count_q >= CNT_W'(1));
    ib_id_valid_1     = (count_q >= CNT_W'(2));
    ib_id_pc_0        = ib_id_valid_0 ? rd0.pc : 32'd0;
    ib_id_insn_0      = ib_id_valid_0 ? rd0.insn : 32'd0;
    ib_id_ptab_addr_0 = ib_id_valid_0 ? rd0.ptab_addr : 5'd0;
    ib_id_pc_1        = ib_id_valid_1 ? rd1.pc : 32'd0;
    ib_id_insn_1      = ib_id_valid_1 ? rd1.insn : 32'd0;
    ib_id_ptab_addr_1 = ib_id_valid_1 ? rd1.ptab_addr : 5'd0;
  end

endmodule
